// File: rtl/alu_pkg.sv
// Shared widths, opcode constants and FSM state type for the ALU arbiter slice.
package alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int OP_W_DEF = 5;

  localparam logic [4:0] OP_NOP = 5'd0;
  localparam logic [4:0] OP_ADD = 5'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  // Index width for an n-entry vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above ptr, wrapping.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  ptr,
  output logic [N-1:0]         grant,
  output logic [idx_w(N)-1:0]  grant_idx,
  output logic                 grant_any
);

  localparam int IW = idx_w(N);

  logic [IW:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      // ptr < N and i < N, so one conditional subtract is a full modulo.
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!grant_any && req[pos[IW-1:0]]) begin
        grant[pos[IW-1:0]] = 1'b1;
        grant_idx          = pos[IW-1:0];
        grant_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU between NUM_REQ requesters: round-robin accept,
// one-cycle issue, fixed-latency wait, then result returned to the owner.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int XLEN    = XLEN_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_rs1_i,
  input  logic [NUM_REQ*XLEN-1:0] req_rs2_i,
  input  logic [NUM_REQ*OP_W-1:0] req_op_i,
  output logic [XLEN-1:0]         alu_rs1_o,
  output logic [XLEN-1:0]         alu_rs2_o,
  output logic [OP_W-1:0]         alu_op_o,
  input  logic [XLEN-1:0]         alu_rd_i,
  output logic [NUM_REQ-1:0]      resp_valid_o,
  input  logic [NUM_REQ-1:0]      resp_ready_i,
  output logic [XLEN-1:0]         resp_rd_o,
  output logic                    busy_o
);

  localparam int         IW       = idx_w(NUM_REQ);
  localparam logic [2:0] CNT_LOAD = 3'(ALU_LAT - 1);

  arb_state_e      state_reg;
  logic [IW-1:0]   ptr_reg;
  logic [IW-1:0]   id_reg;
  logic [2:0]      cnt_reg;
  logic [XLEN-1:0] rs1_reg;
  logic [XLEN-1:0] rs2_reg;
  logic [OP_W-1:0] op_reg;
  logic [XLEN-1:0] rd_reg;

  logic [XLEN-1:0] rs1_arr [NUM_REQ];
  logic [XLEN-1:0] rs2_arr [NUM_REQ];
  logic [OP_W-1:0] op_arr  [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign rs1_arr[gi]      = req_rs1_i[gi*XLEN +: XLEN];
      assign rs2_arr[gi]      = req_rs2_i[gi*XLEN +: XLEN];
      assign op_arr[gi]       = req_op_i[gi*OP_W +: OP_W];
      assign resp_valid_o[gi] = (state_reg == ST_RESP) && (id_reg == IW'(gi));
    end
  endgenerate

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req       (req_valid_i),
    .ptr       (ptr_reg),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready_o = (state_reg == ST_IDLE) ? grant : '0;
  assign alu_rs1_o   = rs1_reg;
  assign alu_rs2_o   = rs2_reg;
  assign alu_op_o    = op_reg;
  assign resp_rd_o   = rd_reg;
  assign busy_o      = (state_reg != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      id_reg    <= '0;
      cnt_reg   <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      op_reg    <= '0;
      rd_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (grant_any) begin
            rs1_reg   <= rs1_arr[grant_idx];
            rs2_reg   <= rs2_arr[grant_idx];
            // Opcode reaches the ALU only while in ISSUE; NOP elsewhere.
            op_reg    <= op_arr[grant_idx];
            id_reg    <= grant_idx;
            ptr_reg   <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          op_reg    <= OP_W'(OP_NOP);
          cnt_reg   <= CNT_LOAD;
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_reg == 3'd0) begin
            rd_reg    <= alu_rd_i;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i[id_reg]) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a fixed-latency ALU model and a
// transaction-level reference for grant order, timing and results.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NR  = 4;
  localparam int XL  = 32;
  localparam int OW  = 5;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [NR-1:0]  v;
  logic [XL-1:0]  a [NR];
  logic [XL-1:0]  b [NR];
  logic [OW-1:0]  o [NR];
  logic [NR-1:0]  rready;

  logic [NR*XL-1:0] rs1_p, rs2_p;
  logic [NR*OW-1:0] op_p;
  logic [NR-1:0]    ready, rvld;
  logic [XL-1:0]    alu_rs1, alu_rs2, alu_rd, rd;
  logic [OW-1:0]    alu_op;
  logic             busy;

  for (genvar gi = 0; gi < NR; gi++) begin : g_pack
    assign rs1_p[gi*XL +: XL] = a[gi];
    assign rs2_p[gi*XL +: XL] = b[gi];
    assign op_p[gi*OW +: OW]  = o[gi];
  end

  alu_arbiter #(
    .NUM_REQ (NR),
    .XLEN    (XL),
    .OP_W    (OW),
    .ALU_LAT (LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (v),
    .req_ready_o  (ready),
    .req_rs1_i    (rs1_p),
    .req_rs2_i    (rs2_p),
    .req_op_i     (op_p),
    .alu_rs1_o    (alu_rs1),
    .alu_rs2_o    (alu_rs2),
    .alu_op_o     (alu_op),
    .alu_rd_i     (alu_rd),
    .resp_valid_o (rvld),
    .resp_ready_i (rready),
    .resp_rd_o    (rd),
    .busy_o       (busy)
  );

  // ALU stand-in: ADD sums, anything else returns zero, LAT edges later.
  logic [XL-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= (alu_op == OP_ADD) ? alu_rs1 + alu_rs2 : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign alu_rd = pipe[LAT-1];

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int winner();
    for (int i = 0; i < NR; i++) begin
      if (v[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
    end
    return -1;
  endfunction

  task automatic new_req(input int k);
    v[k] = 1'b1;
    a[k] = $urandom;
    b[k] = $urandom;
    o[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : OP_ADD;
  endtask

  task automatic set_req(input int k, input logic [31:0] ra, input logic [31:0] rb, input logic [4:0] rop);
    v[k] = 1'b1; a[k] = ra; b[k] = rb; o[k] = rop;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // Entered and left in the high phase of an IDLE cycle.
  task automatic serve_one(input int bp, input bit do_rst, input bit refill, output int gid);
    int w;
    int cyc;
    logic [31:0] ea, eb, expd;
    logic [4:0]  eop;
    logic        hs;
    gid = -1; cyc = 0; w = -1; hs = 1'b0;
    while (1) begin
      @(negedge clk);
      w = winner();
      check_eq("idle_ready", 32'(ready), (w < 0) ? 32'd0 : (32'd1 << w));
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_rvld", 32'(rvld), 32'd0);
      check_eq("idle_aluop", 32'(alu_op), 32'd0);
      if (w >= 0) break;
      if (cyc == 40) begin
        check_eq("grant_timeout", 32'(cyc), 32'd0);
        return;
      end
      cyc++;
      @(posedge clk); #1;
    end
    ea = a[w]; eb = b[w]; eop = o[w];
    expd = (eop == OP_ADD) ? ea + eb : 32'd0;
    gid = w;
    m_ptr = (w + 1) % NR;
    @(posedge clk); #1;
    v[w] = 1'b0;
    if (refill) begin
      if ($urandom_range(0, 1) == 1) new_req(w);
      for (int k = 0; k < NR; k++) begin
        if (!v[k] && $urandom_range(0, 2) == 0) new_req(k);
      end
    end
    @(negedge clk);
    check_eq("issue_op", 32'(alu_op), 32'(eop));
    check_eq("issue_rs1", alu_rs1, ea);
    check_eq("issue_rs2", alu_rs2, eb);
    check_eq("issue_busy", 32'(busy), 32'd1);
    check_eq("issue_ready", 32'(ready), 32'd0);
    check_eq("issue_rvld", 32'(rvld), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      @(posedge clk); #1;
      if (do_rst && i == 1) rst = 1'b1;
      @(negedge clk);
      check_eq("wait_op", 32'(alu_op), 32'd0);
      check_eq("wait_busy", 32'(busy), 32'd1);
      check_eq("wait_rvld", 32'(rvld), 32'd0);
      check_eq("wait_ready", 32'(ready), 32'd0);
      if (do_rst && i == 1) break;
    end
    if (do_rst) begin
      @(posedge clk); #1;
      rst = 1'b0;
      m_ptr = 0;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_rvld", 32'(rvld), 32'd0);
      check_eq("rst_rd", rd, 32'd0);
      check_eq("rst_op", 32'(alu_op), 32'd0);
      check_eq("rst_rs1", alu_rs1, 32'd0);
      check_eq("rst_rs2", alu_rs2, 32'd0);
      $display("txn req=%0d op=%0d aborted by reset", w, eop);
      return;
    end
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      rready = NR'($urandom);
      rready[w] = (c >= bp);
      @(negedge clk);
      check_eq("resp_rvld", 32'(rvld), 32'd1 << w);
      check_eq("resp_rd", rd, expd);
      check_eq("resp_busy", 32'(busy), 32'd1);
      check_eq("resp_ready", 32'(ready), 32'd0);
      check_eq("resp_op", 32'(alu_op), 32'd0);
      if (rready[w]) begin
        hs = 1'b1;
        break;
      end
    end
    check_eq("resp_hs", 32'(hs), 32'd1);
    @(posedge clk); #1;
    rready = '0;
    $display("txn req=%0d op=%0d rs1=%h rs2=%h rd=%h bp=%0d", w, eop, ea, eb, expd, bp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst = 1'b1;
    v = '0;
    rready = '0;
    for (int k = 0; k < NR; k++) begin
      a[k] = '0; b[k] = '0; o[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", 32'(ready), 32'd0);
    check_eq("reset_rvld", 32'(rvld), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_rd", rd, 32'd0);
    check_eq("reset_op", 32'(alu_op), 32'd0);
    check_eq("reset_rs1", alu_rs1, 32'd0);
    rst = 1'b0;

    // Single add from requester 2.
    set_req(2, 32'h5, 32'h7, OP_ADD);
    serve_one(0, 1'b0, 1'b0, g);
    check_eq("single_gid", 32'(g), 32'd2);

    // All four contend from reset: strict round-robin, then wrap to 0.
    pulse_reset();
    for (int k = 0; k < NR; k++) set_req(k, 32'(100 * (k + 1)), 32'(k + 3), OP_ADD);
    for (int k = 0; k < NR; k++) begin
      serve_one(0, 1'b0, 1'b0, g);
      check_eq("rr_order", 32'(g), 32'(k));
    end
    set_req(0, 32'h1234, 32'h1, OP_ADD);
    serve_one(0, 1'b0, 1'b0, g);
    check_eq("rr_wrap", 32'(g), 32'd0);

    // Backpressure on requester 1 while 3 is waiting.
    set_req(1, 32'hAAAA_0000, 32'h0000_5555, OP_ADD);
    set_req(3, 32'h10, 32'h20, OP_ADD);
    serve_one(5, 1'b0, 1'b0, g);
    check_eq("bp_gid", 32'(g), 32'd1);
    serve_one(0, 1'b0, 1'b0, g);
    check_eq("bp_next", 32'(g), 32'd3);

    // Result wrap and a non-add opcode.
    set_req(0, 32'hFFFF_FFFF, 32'h1, OP_ADD);
    serve_one(0, 1'b0, 1'b0, g);
    set_req(2, 32'h3, 32'h4, 5'd7);
    serve_one(1, 1'b0, 1'b0, g);

    // Reset mid-WAIT; pointer must restart at 0 afterwards.
    set_req(1, 32'h9, 32'h9, OP_ADD);
    serve_one(0, 1'b1, 1'b0, g);
    set_req(1, 32'h11, 32'h22, OP_ADD);
    set_req(3, 32'h33, 32'h44, OP_ADD);
    serve_one(0, 1'b0, 1'b0, g);
    check_eq("post_rst_gid", 32'(g), 32'd1);
    serve_one(0, 1'b0, 1'b0, g);

    // Random traffic with occasional resets.
    for (int n = 0; n < 150; n++) begin
      if (v == '0) new_req($urandom_range(0, NR - 1));
      serve_one($urandom_range(0, 3), ($urandom_range(0, 19) == 0), 1'b1, g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin controller that shares the single 32-bit ALU between NUM_REQ requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU's operand and opcode inputs for exactly one cycle. It waits the ALU's fixed pipeline latency, captures the result and returns it to the originating requester over a second valid/ready handshake. It sits between the issue/decode front-ends and the ALU's dmem_rs1/dmem_rs2/trans_instruct/alu_rd interface.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- XLEN, 32, operand/result width
- OP_W, 5, opcode width (matches ALU instruction field)
- ALU_LAT, 1, ALU cycles from operand-sampling edge to valid alu_rd_i (1..7)
- clk_i  in  1  single clock, all logic on posedge
- rst_i  in  1  reset; synchronous, active-high
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  one-hot grant/accept
- req_rs1_i  in  NUM_REQ*XLEN  packed operand A, requester k at [k*XLEN +: XLEN]
- req_rs2_i  in  NUM_REQ*XLEN  packed operand B
- req_op_i  in  NUM_REQ*OP_W  packed opcode
- alu_rs1_o  out  XLEN  to ALU dmem_rs1
- alu_rs2_o  out  XLEN  to ALU dmem_rs2
- alu_op_o  out  OP_W  to ALU trans_instruct
- alu_rd_i  in  XLEN  from ALU alu_rd
- resp_valid_o  out  NUM_REQ  one-hot result valid to owning requester
- resp_ready_i  in  NUM_REQ  per-requester result accept
- resp_rd_o  out  XLEN  result, shared by all requesters
- busy_o  out  1  high in every state except IDLE

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - req_ready_o[g] = 1 only for the winner g: the first k with req_valid_i[k], searching upward from pointer ptr and wrapping modulo NUM_REQ.
  - req_ready_o depends combinationally on req_valid_i; requesters must not make valid depend on ready.
  - On accept: latch rs1/rs2/op and id = g; set ptr = (g+1) mod NUM_REQ; go to ISSUE.
  - No valid request: stay in IDLE, ptr unchanged.
- ISSUE (1 cycle): alu_rs1_o/alu_rs2_o/alu_op_o = latched values. Load cnt = ALU_LAT-1. Go to WAIT.
- WAIT:
  - If cnt == 0: capture alu_rd_i into resp_rd_o; go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - resp_valid_o[id] = 1; resp_rd_o held stable.
  - On resp_ready_i[id]: go to IDLE.
  - resp_ready_i bits of other requesters are ignored.
- Outside ISSUE, alu_op_o = OP_NOP (0), which yields a zero ALU result. alu_rs1_o/alu_rs2_o hold their last latched values.
- Requesters hold req_valid_i and operands stable until granted. A request whose valid drops before grant is simply not serviced.
- The arbiter does not interpret opcodes. It forwards them verbatim and is unaware of any ALU illegal-op behaviour.

## Timing
- Reset state:
  - FSM = IDLE, ptr = 0, cnt = 0, id = 0.
  - req_ready_o driven combinationally from req_valid_i; 0 whenever no request is valid.
  - resp_valid_o = 0, resp_rd_o = 0, alu_rs1_o = 0, alu_rs2_o = 0, alu_op_o = 0, busy_o = 0.
- Accept at cycle T:
  - ISSUE at T+1.
  - Capture at T+1+ALU_LAT.
  - resp_valid_o rises at T+2+ALU_LAT.
- Response accepted at cycle R: IDLE at R+1; next accept earliest at R+1.
- Peak throughput: one operation per ALU_LAT+3 cycles when resp_ready_i is held high.
- Simultaneous requests are served strictly round-robin. No requester waits more than NUM_REQ-1 grants.
- Reset in any state, including mid-WAIT or RESP:
  - Next cycle is the full reset state.
  - The in-flight result is discarded and no resp_valid_o pulse is emitted.
  - The ALU is expected to be reset on the same cycle.
- resp_valid_o never deasserts before its handshake; resp_rd_o is stable throughout RESP.

## Structure
- alu_pkg holds: XLEN and OP_W defaults, opcode constants OP_NOP = 5'd0 and OP_ADD = 5'd1, and the FSM state enum.
- The arbitration is one sub-module, rr_arbiter: combinational grant from req vector plus ptr, one-hot and index outputs, parameter N. The ptr register stays in alu_arbiter.

## Test plan
- Single add: requester 2, rs1 = 0x0000_0005, rs2 = 0x0000_0007, op = 1, ALU_LAT = 1, resp_ready_i high.
  - Expect accept at T, resp_valid_o = 4'b0100 at T+3, resp_rd_o = 0x0000_000C, busy_o high T+1..T+3.
- All four requesters valid from reset, each with op = 1 and distinct operands.
  - Expect grant order 0, 1, 2, 3, then 0 again.
  - Each result is returned only to its owner, with correct sums.
- Backpressure: resp_ready_i[1] low for 5 cycles during RESP.
  - resp_valid_o[1] and resp_rd_o are held; no new req_ready_o is asserted until the handshake.
- Reset asserted in WAIT with ALU_LAT = 3.
  - All outputs reach reset values the next cycle; no resp_valid_o pulse appears.
  - A request pending at deassert is served from ptr = 0.
- ALU_LAT = 3, op = 1, 0xFFFF_FFFF + 0x0000_0001.
  - resp_valid_o at T+5; resp_rd_o = 0x0000_0000 (wrap).
- op = 5'd7 (ALU default path): result 0 is returned normally. alu_op_o = 0 in every cycle except ISSUE.
